rr_arb_lock: RTL and testbench
==============================

Name: rr_arb_lock

Overview:
- Round-robin arbiter with multi-beat lock. Shares one downstream resource (bus, write port, pipeline slot) among W requesters.
- Priority rotates by building a unary "above last winner" mask from the one-hot last-grant register (leftward, exclusive) and splitting requests into high and low priority halves.
- Once a multi-beat transaction starts, the grant is held until its final beat or until a beat-count watchdog fires.

Parameters:
- W, 4, number of requesters (W >= 2).
- MAX_BEATS, 16, maximum accepted beats per locked transaction before forced release (>= 1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_req  in  W  per-requester request; must stay asserted while that requester is locked.
- i_last  in  1  accompanies i_ack; marks final beat of the granted transaction.
- i_ack  in  1  downstream accepts the current beat.
- o_gnt  out  W  one-hot grant (all-zero when no valid grant).
- o_gnt_vld  out  1  a grant is presented (|o_gnt).
- o_gnt_enc  out  $clog2(W)  binary index of o_gnt (0 when o_gnt_vld=0).
- o_locked  out  1  arbiter is mid-transaction.
- o_timeout  out  1  one-cycle pulse: lock forcibly released by watchdog.

Behaviour:
- Registered state:
  - last_gnt[W]: one-hot, reset value 1<<(W-1), so requester 0 has top priority after reset.
  - state: ARB or LOCKED, reset to ARB.
  - lock_gnt[W]: reset 0.
  - beat_cnt[$clog2(MAX_BEATS+1)]: reset 0.
- Reset values of outputs: o_gnt=0, o_gnt_vld=0, o_gnt_enc=0, o_locked=0, o_timeout=0.
- ARB selection (combinational, zero latency from i_req to o_gnt):
  - hi_mask = bits strictly above the set bit of last_gnt.
  - req_hi = i_req & hi_mask.
  - o_gnt = lowest set bit of req_hi if req_hi != 0, else lowest set bit of i_req.
  - i_req=0 gives o_gnt=0 and o_gnt_vld=0.
- LOCKED: o_gnt = lock_gnt & i_req. Other requests are ignored. If the locked requester drops i_req, o_gnt=0 but the lock is held; this is a protocol violation and must be covered by an assertion.
- i_ack with o_gnt_vld=0 is ignored and must be covered by an assertion.
- Beat accepted when o_gnt_vld & i_ack:
  - ARB, i_last=1: single-beat transaction. last_gnt<=o_gnt, stay ARB.
  - ARB, i_last=0: state<=LOCKED, lock_gnt<=o_gnt, beat_cnt<=1. If MAX_BEATS==1, instead treat as a timeout (see below).
  - LOCKED, i_last=1: state<=ARB, last_gnt<=lock_gnt, beat_cnt<=0.
  - LOCKED, i_last=0, beat_cnt+1 == MAX_BEATS: state<=ARB, last_gnt<=lock_gnt, beat_cnt<=0, o_timeout<=1 for the next cycle.
  - LOCKED, otherwise: beat_cnt<=beat_cnt+1.
- o_locked = (state==LOCKED), registered.
- o_timeout is registered and high exactly one cycle.
- last_gnt updates only at transaction end, never on a mid-transaction beat.
- Wrap-around: when last_gnt is the MSB, hi_mask=0, so selection falls to the lowest requester.
- Simultaneous events: rotation takes effect the cycle after the final beat. A new request arriving in the same cycle as the final ack competes in the next cycle.
- Reset mid-transaction: next cycle is ARB with last_gnt=1<<(W-1) and the counter cleared; any lock is abandoned.
- No combinational path from i_ack/i_last to o_gnt.

Test Plan:
- Reset, W=4, i_req=4'b1111, i_ack=1, i_last=1 every cycle -> o_gnt sequence 0001,0010,0100,1000,0001; o_gnt_enc 0,1,2,3,0.
- last_gnt=0100 (after granting req2), i_req=4'b0011 -> o_gnt=0001 (wrap; req_hi includes only bit 3, which is not requesting).
- i_req=4'b0110; accept beats on req1 with i_last=0,0,1 while req2 is held high -> o_gnt=0010 for all 3 beats, o_locked=1 after the first beat; next cycle o_gnt=0100.
- MAX_BEATS=4, req0 locked, i_last never set -> after the 4th ack o_timeout pulses one cycle, o_locked=0, and the next grant goes to the next requester in rotation.
- rst asserted while LOCKED on req3 with i_req=4'b1111 -> cycle after reset release o_gnt=0001, o_locked=0, o_timeout=0.
- i_req=0 with i_ack pulses -> o_gnt=0, last_gnt unchanged, no state change.

Source files
------------

// File: rtl/rr_arb_lock.sv
// Round-robin arbiter with multi-beat lock and a beat-count watchdog.
// Grant selection is combinational from i_req and registered state only;
// i_ack/i_last affect state at the next edge and never reach o_gnt directly.
module rr_arb_lock #(
   parameter int W         = 4,
   parameter int MAX_BEATS = 16,
   localparam int EW       = (W > 1) ? $clog2(W) : 1,
   localparam int CW       = $clog2(MAX_BEATS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  i_req,
   input  logic          i_last,
   input  logic          i_ack,
   output logic [W-1:0]  o_gnt,
   output logic          o_gnt_vld,
   output logic [EW-1:0] o_gnt_enc,
   output logic          o_locked,
   output logic          o_timeout
);

   typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_e;

   state_e        state_q,     state_d;
   logic [W-1:0]  last_gnt_q,  last_gnt_d;
   logic [W-1:0]  lock_gnt_q,  lock_gnt_d;
   logic [CW-1:0] beat_cnt_q,  beat_cnt_d;
   logic          locked_q,    locked_d;
   logic          timeout_q,   timeout_d;

   logic [W-1:0]  hi_mask;
   logic [W-1:0]  req_hi;
   logic [W-1:0]  arb_gnt;
   logic          accept;

   // Rotating-priority pick: prefer requesters strictly above the last winner.
   always_comb begin
      logic seen;
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and a latch is never inferred.
      seen    = 1'b0;
      hi_mask = '0;
      for (int i = 0; i < W; i++) begin
         hi_mask[i] = seen;
         seen       = seen | last_gnt_q[i];
      end
      req_hi = i_req & hi_mask;
      if (req_hi != '0) arb_gnt = req_hi & (~req_hi + W'(1));
      else              arb_gnt = i_req  & (~i_req  + W'(1));
   end

   // Present the grant: held requester while locked, rotating pick otherwise.
   always_comb begin
      o_gnt = '0;
      if (!rst) o_gnt = (state_q == LOCKED) ? (lock_gnt_q & i_req) : arb_gnt;
      o_gnt_vld = |o_gnt;
      o_gnt_enc = '0;
      for (int i = 0; i < W; i++) begin
         if (o_gnt[i]) o_gnt_enc = EW'(i);
      end
      accept = o_gnt_vld & i_ack;
   end

   // Next-state: transaction start, beat counting, normal end and watchdog.
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      lock_gnt_d = lock_gnt_q;
      beat_cnt_d = beat_cnt_q;
      timeout_d  = 1'b0;
      if (accept) begin
         if (state_q == ARB) begin
            if (i_last) begin
               last_gnt_d = o_gnt;
            end else if (MAX_BEATS == 1) begin
               last_gnt_d = o_gnt;
               timeout_d  = 1'b1;
            end else begin
               state_d    = LOCKED;
               lock_gnt_d = o_gnt;
               beat_cnt_d = CW'(1);
            end
         end else begin
            if (i_last || (beat_cnt_q + CW'(1) == CW'(MAX_BEATS))) begin
               state_d    = ARB;
               last_gnt_d = lock_gnt_q;
               lock_gnt_d = '0;
               beat_cnt_d = '0;
               timeout_d  = !i_last;
            end else begin
               beat_cnt_d = beat_cnt_q + CW'(1);
            end
         end
      end
      locked_d = (state_d == LOCKED);
   end

   // State registers with synchronous reset; requester 0 leads after reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q    <= ARB;
         last_gnt_q <= W'(1) << (W - 1);
         lock_gnt_q <= '0;
         beat_cnt_q <= '0;
         locked_q   <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         lock_gnt_q <= lock_gnt_d;
         beat_cnt_q <= beat_cnt_d;
         locked_q   <= locked_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_locked  = locked_q;
   assign o_timeout = timeout_q;

   // A locked requester must keep requesting until its transaction ends.
   a_lock_req_held : assert property (@(posedge clk) disable iff (rst)
      (state_q == LOCKED) |-> |(i_req & lock_gnt_q));

   // Acks with no grant presented are legal but ignored; track that they occur.
   c_ack_no_gnt : cover property (@(posedge clk) disable iff (rst)
      i_ack && !o_gnt_vld);

   // Grant is always one-hot or idle.
   a_gnt_onehot : assert property (@(posedge clk) disable iff (rst)
      $onehot0(o_gnt));

endmodule

// File: tb/tb_rr_arb_lock.sv
// Directed bench for rr_arb_lock: the driver applies one vector per cycle and
// queues the hand-computed expected outputs; the monitor pops and compares.
module tb_rr_arb_lock;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] i_req;
   logic         i_last;
   logic         i_ack;
   logic [W-1:0] o_gnt;
   logic         o_gnt_vld;
   logic [1:0]   o_gnt_enc;
   logic         o_locked;
   logic         o_timeout;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [W-1:0] gnt;
      logic         locked;
      logic         timeout;
      string        name;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   rr_arb_lock #(.W(W), .MAX_BEATS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_last    (i_last),
      .i_ack     (i_ack),
      .o_gnt     (o_gnt),
      .o_gnt_vld (o_gnt_vld),
      .o_gnt_enc (o_gnt_enc),
      .o_locked  (o_locked),
      .o_timeout (o_timeout)
   );

   function automatic logic [1:0] enc_of(input logic [W-1:0] g);
      logic [1:0] e;
      e = '0;
      for (int i = 0; i < W; i++) if (g[i]) e = 2'(i);
      return e;
   endfunction

   // Apply one vector just after the edge, queue its expectation, wait a cycle.
   task automatic step(input logic r, input logic [W-1:0] req, input logic ack,
                       input logic last, input logic [W-1:0] eg, input logic el,
                       input logic et, input string name);
      exp_t e;
      rst    = r;
      i_req  = req;
      i_ack  = ack;
      i_last = last;
      e.gnt = eg; e.locked = el; e.timeout = et; e.name = name;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: mid-cycle, compare the presented outputs with the queued vector.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_checks++;
         if (o_gnt === e.gnt && o_gnt_vld === (|e.gnt) && o_gnt_enc === enc_of(e.gnt)
             && o_locked === e.locked && o_timeout === e.timeout) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got gnt=%b vld=%b enc=%0d locked=%b timeout=%b, want gnt=%b vld=%b enc=%0d locked=%b timeout=%b",
                     e.name, o_gnt, o_gnt_vld, o_gnt_enc, o_locked, o_timeout,
                     e.gnt, |e.gnt, enc_of(e.gnt), e.locked, e.timeout);
         end
      end
   end

   initial begin
      rst = 1'b1; i_req = 4'b1111; i_ack = 1'b1; i_last = 1'b1;
      @(posedge clk); #1;
      // Reset held: grant gated, registered outputs cleared.
      step(1, 4'b1111, 1, 1, 4'b0000, 0, 0, "reset");
      // Full rotation with single-beat transactions.
      step(0, 4'b1111, 1, 1, 4'b0001, 0, 0, "rot0");
      step(0, 4'b1111, 1, 1, 4'b0010, 0, 0, "rot1");
      step(0, 4'b1111, 1, 1, 4'b0100, 0, 0, "rot2");
      step(0, 4'b1111, 1, 1, 4'b1000, 0, 0, "rot3");
      step(0, 4'b1111, 1, 1, 4'b0001, 0, 0, "rot_wrap");
      step(0, 4'b1111, 1, 1, 4'b0010, 0, 0, "rot1b");
      step(0, 4'b1111, 1, 1, 4'b0100, 0, 0, "rot2b");
      // last_gnt=0100: only bit 3 is above, not requesting -> wrap to req0.
      step(0, 4'b0011, 0, 0, 4'b0001, 0, 0, "wrap_low");
      step(0, 4'b1011, 0, 0, 4'b1000, 0, 0, "hi_half");
      // Three-beat lock on req1 while req2 keeps requesting.
      step(0, 4'b0110, 1, 0, 4'b0010, 0, 0, "lock_b1");
      step(0, 4'b0110, 1, 0, 4'b0010, 1, 0, "lock_b2");
      step(0, 4'b0110, 1, 1, 4'b0010, 1, 0, "lock_b3");
      step(0, 4'b0110, 0, 0, 4'b0100, 0, 0, "after_lock");
      // Watchdog: req0 locked, never signals last; fourth ack forces release.
      step(0, 4'b0001, 1, 0, 4'b0001, 0, 0, "wd_b1");
      step(0, 4'b1111, 1, 0, 4'b0001, 1, 0, "wd_b2");
      step(0, 4'b1111, 1, 0, 4'b0001, 1, 0, "wd_b3");
      step(0, 4'b1111, 1, 0, 4'b0001, 1, 0, "wd_b4");
      step(0, 4'b1111, 0, 0, 4'b0010, 0, 1, "wd_pulse");
      step(0, 4'b1111, 0, 0, 4'b0010, 0, 0, "wd_pulse_end");
      // Acks with no requests: no grant, no state change.
      step(0, 4'b0000, 1, 1, 4'b0000, 0, 0, "idle_ack_last");
      step(0, 4'b0000, 1, 0, 4'b0000, 0, 0, "idle_ack");
      step(0, 4'b1111, 0, 0, 4'b0010, 0, 0, "idle_no_change");
      // Lock req3, then reset mid-transaction.
      step(0, 4'b1000, 1, 0, 4'b1000, 0, 0, "r3_b1");
      step(0, 4'b1111, 1, 0, 4'b1000, 1, 0, "r3_b2");
      step(1, 4'b1111, 0, 0, 4'b0000, 1, 0, "rst_mid");
      step(0, 4'b1111, 0, 0, 4'b0001, 0, 0, "post_rst");
      step(0, 4'b1111, 1, 1, 4'b0001, 0, 0, "post_rst_ack");
      step(0, 4'b1111, 0, 0, 4'b0010, 0, 0, "post_rst_rot");
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
